// File: rtl/memory_access_stage_pkg.sv
// Shared types for the memory access stage: funct3 width encodings, byte-lane
// masks, the Execute->Memory and Memory->Writeback payloads, and the held access.
package memory_access_stage_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } memWidth_e;

  localparam logic [3:0] LANE_BYTE = 4'b0001;
  localparam logic [3:0] LANE_HALF = 4'b0011;
  localparam logic [3:0] LANE_WORD = 4'b1111;

  typedef struct packed {
    logic        valid;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] storeData;
    logic [31:0] result;
    logic [4:0]  destinationRegister;
    logic        writebackEnable;
    logic        illegal;
  } executeMemoryPayload_t;

  typedef struct packed {
    logic        valid;
    logic        writebackEnable;
    logic        illegal;
    logic [4:0]  destinationRegister;
    logic [31:0] data;
  } memoryWritebackPayload_t;

  // Everything needed to keep a bus access stable and finish it later.
  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [1:0]  offset;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [3:0]  byteEnable;
    logic [4:0]  rd;
    logic        writebackEnable;
    logic [31:0] result;
    logic        dropped;
  } pendingAccess_t;

endpackage

// File: rtl/memory_access_stage_load.sv
// Load lane select and sign/zero extension of a raw data-memory word.
module load_aligner
  import memory_access_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rawWord,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rawWord >> {offset, 3'b000};
    case (memWidth_e'(funct3))
      MEM_B:   data = {{24{shifted[7]}}, shifted[7:0]};
      MEM_BU:  data = {24'h0, shifted[7:0]};
      MEM_H:   data = {{16{shifted[15]}}, shifted[15:0]};
      MEM_HU:  data = {16'h0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// Memory stage between Execute and Writeback: single-port request/ready data
// memory access with a WAIT-state watchdog. Optional macro MISALIGNED_TRAP_EN.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  executeMemoryPayload_t   executeMemoryPayload,
  output logic                    memoryStall,
  output logic                    memRequest,
  output logic                    memWriteEnable,
  output logic [ADDR_WIDTH-1:0]   memAddress,
  output logic [31:0]             memWriteData,
  output logic [3:0]              memByteEnable,
  input  logic                    memReady,
  input  logic [31:0]             memReadData,
  output memoryWritebackPayload_t memoryWritebackPayload
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  executeMemoryPayload_t   ex;
  pendingAccess_t          cur, held, active;
  memoryWritebackPayload_t nextPayload;
  logic [0:0]              state;
  logic [CW-1:0]           waitCount;
  logic                    isMem, funct3Ok, isHalf, isWord, trap, issue, timeout, dropResult;
  logic [3:0]              laneMask;
  logic [31:0]             storeWord, loadData;

  assign ex    = executeMemoryPayload;
  assign isMem = ex.valid & (ex.memRead | ex.memWrite) & ~ex.illegal;

  always_comb begin
    funct3Ok  = 1'b0;
    isHalf    = 1'b0;
    isWord    = 1'b0;
    laneMask  = LANE_BYTE;
    storeWord = ex.storeData;
    case (memWidth_e'(ex.funct3))
      MEM_B:  begin funct3Ok = 1'b1;         storeWord = {4{ex.storeData[7:0]}}; end
      MEM_BU: begin funct3Ok = ~ex.memWrite; storeWord = {4{ex.storeData[7:0]}}; end
      MEM_H:  begin funct3Ok = 1'b1;         isHalf = 1'b1; laneMask = LANE_HALF;
                    storeWord = {2{ex.storeData[15:0]}}; end
      MEM_HU: begin funct3Ok = ~ex.memWrite; isHalf = 1'b1; laneMask = LANE_HALF;
                    storeWord = {2{ex.storeData[15:0]}}; end
      MEM_W:  begin funct3Ok = 1'b1;         isWord = 1'b1; laneMask = LANE_WORD; end
      default: ;
    endcase

    cur                 = '0;
    cur.write           = ex.memWrite;
    cur.funct3          = ex.funct3;
    cur.offset          = ex.address[1:0];
    // Natural alignment is forced here; with the trap enabled misaligned ops never issue.
    if (isHalf) cur.offset[0] = 1'b0;
    if (isWord) cur.offset    = 2'b00;
    cur.address         = {ex.address[31:2], 2'b00};
    cur.writeData       = storeWord;
    cur.byteEnable      = laneMask << cur.offset;
    cur.rd              = ex.destinationRegister;
    cur.writebackEnable = ex.writebackEnable & ~ex.memWrite;
    cur.result          = ex.result;
  end

`ifdef MISALIGNED_TRAP_EN
  assign trap = isMem & funct3Ok & ((isHalf & ex.address[0]) | (isWord & (|ex.address[1:0])));
`else
  assign trap = 1'b0;
`endif

  assign issue      = reset & (state == IDLE) & isMem & funct3Ok & ~trap & ~flush;
  assign active     = (state == WAIT) ? held : cur;
  assign dropResult = flush | active.dropped;

  always_comb begin
    timeout = 1'b0;
    if (MAX_WAIT != 0 && state == WAIT && !memReady)
      timeout = (waitCount == CW'(MAX_WAIT - 1));
  end

  always_comb begin
    memRequest     = issue | (reset & (state == WAIT));
    memWriteEnable = memRequest & active.write;
    memAddress     = memRequest ? active.address[ADDR_WIDTH-1:0] : '0;
    memWriteData   = memRequest ? active.writeData : '0;
    memByteEnable  = memRequest ? active.byteEnable : '0;
    memoryStall    = memRequest & ~memReady & ~timeout;
  end

  load_aligner u_load_aligner (
    .funct3  (active.funct3),
    .offset  (active.offset),
    .rawWord (memReadData),
    .data    (loadData)
  );

  always_comb begin
    nextPayload = '0;
    if (memRequest && (memReady || timeout)) begin
      nextPayload.valid               = ~dropResult;
      nextPayload.writebackEnable     = active.writebackEnable;
      nextPayload.illegal             = timeout;
      nextPayload.destinationRegister = active.rd;
      nextPayload.data                = active.write ? active.result : loadData;
    end else if (state == IDLE && ex.valid && !flush && !issue) begin
      nextPayload.valid               = 1'b1;
      nextPayload.writebackEnable     = ex.writebackEnable;
      nextPayload.illegal             = ex.illegal;
      nextPayload.destinationRegister = ex.destinationRegister;
      nextPayload.data                = ex.result;
      // A memory op that did not issue is either a bad funct3 or a misalignment trap.
      if (isMem) begin
        nextPayload.illegal = 1'b1;
        if (trap) nextPayload.data = ex.address;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state                  <= IDLE;
      held                   <= '0;
      waitCount              <= '0;
      memoryWritebackPayload <= '0;
    end else begin
      memoryWritebackPayload <= nextPayload;
      if (state == IDLE) begin
        if (issue && !memReady) begin
          state     <= WAIT;
          held      <= cur;
          waitCount <= '0;
        end
      end else begin
        held.dropped <= held.dropped | flush;
        waitCount    <= waitCount + CW'(1);
        if (memReady || timeout) state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage built with MAX_WAIT=4.
module tb_memory_access_stage;
  import memory_access_stage_pkg::*;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic                    flush = 1'b0;
  executeMemoryPayload_t   executeMemoryPayload = '0;
  logic                    memoryStall, memRequest, memWriteEnable;
  logic [31:0]             memAddress, memWriteData;
  logic [3:0]              memByteEnable;
  logic                    memReady = 1'b0;
  logic [31:0]             memReadData = '0;
  memoryWritebackPayload_t memoryWritebackPayload;

  memoryWritebackPayload_t expq[$];
  memoryWritebackPayload_t want, got;
  int checks = 0;
  int errors = 0;

  memory_access_stage #(.ADDR_WIDTH(32), .MAX_WAIT(4)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .flush                  (flush),
    .executeMemoryPayload   (executeMemoryPayload),
    .memoryStall            (memoryStall),
    .memRequest             (memRequest),
    .memWriteEnable         (memWriteEnable),
    .memAddress             (memAddress),
    .memWriteData           (memWriteData),
    .memByteEnable          (memByteEnable),
    .memReady               (memReady),
    .memReadData            (memReadData),
    .memoryWritebackPayload (memoryWritebackPayload)
  );

  always #5 clock = ~clock;

  function automatic executeMemoryPayload_t op(input logic isLoad, input logic isStore,
      input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sdata,
      input logic [31:0] res, input logic [4:0] rd, input logic wben);
    executeMemoryPayload_t p;
    p.valid = 1'b1; p.memRead = isLoad; p.memWrite = isStore; p.funct3 = f3;
    p.address = addr; p.storeData = sdata; p.result = res;
    p.destinationRegister = rd; p.writebackEnable = wben; p.illegal = 1'b0;
    return p;
  endfunction

  function automatic memoryWritebackPayload_t wbp(input logic v, input logic we,
      input logic ill, input logic [4:0] rd, input logic [31:0] d);
    memoryWritebackPayload_t p;
    p.valid = v; p.writebackEnable = we; p.illegal = ill; p.destinationRegister = rd; p.data = d;
    return p;
  endfunction

  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  task automatic drive_idle();
    executeMemoryPayload = '0; memReady = 1'b0; flush = 1'b0; memReadData = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    executeMemoryPayload = op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 5'd1, 1'b1);
    memReady = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({memRequest, memoryStall, memWriteEnable, memByteEnable} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: req=%b stall=%b we=%b be=%b required all 0",
                         memRequest, memoryStall, memWriteEnable, memByteEnable);
    end
    checks++;
    if (memAddress !== 32'h0 || memWriteData !== 32'h0) begin
      errors++; $display("FAIL reset_bus: addr=%h wdata=%h required 0 0", memAddress, memWriteData);
    end
    checks++;
    if (memoryWritebackPayload !== '0) begin
      errors++; $display("FAIL reset_payload: got %h required 0", memoryWritebackPayload);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    drive_idle();
    next_cycle();
  endtask

  task automatic test_alu_ops();
    executeMemoryPayload_t   ops  [3];
    memoryWritebackPayload_t exps [3];
    ops[0] = op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_1234, 5'd5, 1'b1);
    exps[0] = wbp(1'b1, 1'b1, 1'b0, 5'd5, 32'h0000_1234);
    ops[1] = op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'hDEAD_0001, 5'd3, 1'b1);
    ops[1].illegal = 1'b1;
    exps[1] = wbp(1'b1, 1'b1, 1'b1, 5'd3, 32'hDEAD_0001);
    ops[2] = op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'd31, 1'b0);
    exps[2] = wbp(1'b1, 1'b0, 1'b0, 5'd31, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      executeMemoryPayload = ops[i];
      expq.push_back(exps[i]);
      @(negedge clock);
      checks++;
      if (memRequest !== 1'b0 || memoryStall !== 1'b0) begin
        errors++; $display("FAIL alu_no_request[%0d]: req=%b stall=%b required 0 0", i, memRequest, memoryStall);
      end
      if (i > 0) begin
        checks++; got = memoryWritebackPayload; want = expq.pop_front();
        if (got !== want) begin
          errors++; $display("FAIL alu_payload[%0d]: got %h required %h", i - 1, got, want);
        end
      end
      next_cycle();
    end
    drive_idle();
    @(negedge clock);
    checks++; got = memoryWritebackPayload; want = expq.pop_front();
    if (got !== want) begin
      errors++; $display("FAIL alu_payload[2]: got %h required %h", got, want);
    end
    next_cycle();
  endtask

  task automatic test_illegal_funct3();
    executeMemoryPayload = op(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 5'd6, 1'b1);
    memReady = 1'b1;
    @(negedge clock);
    checks++;
    if (memRequest !== 1'b0) begin
      errors++; $display("FAIL bad_funct3_request: req=%b required 0", memRequest);
    end
    next_cycle();
    drive_idle();
    @(negedge clock);
    checks++;
    if (memoryWritebackPayload.valid !== 1'b1 || memoryWritebackPayload.illegal !== 1'b1) begin
      errors++; $display("FAIL bad_funct3_payload: valid=%b illegal=%b required 1 1",
                         memoryWritebackPayload.valid, memoryWritebackPayload.illegal);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back_loads();
    logic [2:0]  f3   [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [31:0] addr [6] = '{32'h103, 32'h101, 32'h100, 32'h102, 32'h104, 32'h100};
    logic [31:0] raw  [6] = '{32'h80AA_BBCC, 32'h80AA_BBCC, 32'h80AA_BBCC, 32'h80AA_BBCC,
                              32'h1234_5678, 32'h80AA_BB7F};
    logic [31:0] res  [6] = '{32'hFFFF_FF80, 32'h0000_00BB, 32'hFFFF_BBCC, 32'h0000_80AA,
                              32'h1234_5678, 32'h0000_007F};
    for (int i = 0; i < 6; i++) begin
      executeMemoryPayload = op(1'b1, 1'b0, f3[i], addr[i], 32'h0, 32'h0, 5'(i + 10), 1'b1);
      memReadData = raw[i];
      memReady = 1'b1;
      expq.push_back(wbp(1'b1, 1'b1, 1'b0, 5'(i + 10), res[i]));
      @(negedge clock);
      checks++;
      if (memRequest !== 1'b1 || memoryStall !== 1'b0 || memWriteEnable !== 1'b0 ||
          memAddress !== (addr[i] & 32'hFFFF_FFFC)) begin
        errors++; $display("FAIL load_request[%0d]: req=%b stall=%b we=%b addr=%h required 1 0 0 %h",
                           i, memRequest, memoryStall, memWriteEnable, memAddress, addr[i] & 32'hFFFF_FFFC);
      end
      if (i > 0) begin
        checks++; got = memoryWritebackPayload; want = expq.pop_front();
        if (got !== want) begin
          errors++; $display("FAIL load_payload[%0d]: got %h required %h", i - 1, got, want);
        end
      end
      next_cycle();
    end
    drive_idle();
    @(negedge clock);
    checks++; got = memoryWritebackPayload; want = expq.pop_front();
    if (got !== want) begin
      errors++; $display("FAIL load_payload[5]: got %h required %h", got, want);
    end
    next_cycle();
  endtask

  task automatic test_load_wait();
    int stallCycles = 0;
    executeMemoryPayload = op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h0, 5'd7, 1'b1);
    memReadData = 32'h80AA_BBCC;
    expq.push_back(wbp(1'b1, 1'b1, 1'b0, 5'd7, 32'hFFFF_FF80));
    for (int c = 0; c < 4; c++) begin
      memReady = (c == 3);
      @(negedge clock);
      if (memoryStall === 1'b1) stallCycles++;
      checks++;
      if (memRequest !== 1'b1 || memAddress !== 32'h100 || memWriteEnable !== 1'b0) begin
        errors++; $display("FAIL lb_wait_request[%0d]: req=%b addr=%h we=%b required 1 00000100 0",
                           c, memRequest, memAddress, memWriteEnable);
      end
      if (c > 0) begin
        checks++;
        if (memoryWritebackPayload.valid !== 1'b0) begin
          errors++; $display("FAIL lb_wait_bubble[%0d]: valid=%b required 0", c, memoryWritebackPayload.valid);
        end
      end
      next_cycle();
    end
    checks++;
    if (stallCycles != 3) begin
      errors++; $display("FAIL lb_stall_cycles: got %0d required 3", stallCycles);
    end
    drive_idle();
    @(negedge clock);
    checks++; got = memoryWritebackPayload; want = expq.pop_front();
    if (got !== want || memRequest !== 1'b0) begin
      errors++; $display("FAIL lb_wait_payload: got %h req=%b required %h req=0", got, memRequest, want);
    end
    next_cycle();
  endtask

  task automatic test_store_lanes();
    logic [2:0]  f3    [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] addr  [3] = '{32'h201, 32'h202, 32'h204};
    logic [31:0] sdata [3] = '{32'h1234_56A5, 32'h0000_BEEF, 32'hCAFE_F00D};
    logic [3:0]  be    [3] = '{4'b0010, 4'b1100, 4'b1111};
    logic [31:0] wdata [3] = '{32'hA5A5_A5A5, 32'hBEEF_BEEF, 32'hCAFE_F00D};
    logic [31:0] waddr [3] = '{32'h200, 32'h200, 32'h204};
    for (int i = 0; i < 3; i++) begin
      executeMemoryPayload = op(1'b0, 1'b1, f3[i], addr[i], sdata[i], 32'h0, 5'(i + 20), 1'b1);
      memReady = 1'b1;
      expq.push_back(wbp(1'b1, 1'b0, 1'b0, 5'(i + 20), 32'h0));
      @(negedge clock);
      checks++;
      if (memRequest !== 1'b1 || memWriteEnable !== 1'b1 || memoryStall !== 1'b0 ||
          memByteEnable !== be[i] || memWriteData !== wdata[i] || memAddress !== waddr[i]) begin
        errors++; $display("FAIL store_request[%0d]: req=%b we=%b stall=%b be=%b wdata=%h addr=%h required 1 1 0 %b %h %h",
                           i, memRequest, memWriteEnable, memoryStall, memByteEnable, memWriteData, memAddress,
                           be[i], wdata[i], waddr[i]);
      end
      next_cycle();
      drive_idle();
      @(negedge clock);
      checks++; got = memoryWritebackPayload; want = expq.pop_front();
      if ({got.valid, got.writebackEnable, got.illegal, got.destinationRegister} !==
          {want.valid, want.writebackEnable, want.illegal, want.destinationRegister}) begin
        errors++; $display("FAIL store_payload[%0d]: got %h required valid/wb/ill/rd of %h", i, got, want);
      end
      next_cycle();
    end
  endtask

  task automatic test_misaligned();
`ifdef MISALIGNED_TRAP_EN
    logic [31:0] addr [2] = '{32'h101, 32'h203};
    for (int i = 0; i < 2; i++) begin
      executeMemoryPayload = op(i == 0, i == 1, (i == 0) ? 3'b010 : 3'b001, addr[i],
                                32'h0000_BEEF, 32'h0, 5'd12, 1'b1);
      memReady = 1'b1;
      @(negedge clock);
      checks++;
      if (memRequest !== 1'b0 || memoryStall !== 1'b0) begin
        errors++; $display("FAIL trap_request[%0d]: req=%b stall=%b required 0 0", i, memRequest, memoryStall);
      end
      next_cycle();
      drive_idle();
      @(negedge clock);
      checks++;
      if (memoryWritebackPayload.valid !== 1'b1 || memoryWritebackPayload.illegal !== 1'b1 ||
          memoryWritebackPayload.data !== addr[i]) begin
        errors++; $display("FAIL trap_payload[%0d]: got %h required valid=1 illegal=1 data=%h",
                           i, memoryWritebackPayload, addr[i]);
      end
      next_cycle();
    end
`else
    executeMemoryPayload = op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 5'd12, 1'b1);
    memReadData = 32'h1234_5678;
    memReady = 1'b1;
    expq.push_back(wbp(1'b1, 1'b1, 1'b0, 5'd12, 32'h1234_5678));
    @(negedge clock);
    checks++;
    if (memRequest !== 1'b1 || memAddress !== 32'h100) begin
      errors++; $display("FAIL lw_forced_align: req=%b addr=%h required 1 00000100", memRequest, memAddress);
    end
    next_cycle();
    executeMemoryPayload = op(1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 32'h0, 5'd13, 1'b1);
    memReadData = 32'h80AA_BBCC;
    expq.push_back(wbp(1'b1, 1'b1, 1'b0, 5'd13, 32'hFFFF_80AA));
    @(negedge clock);
    checks++; got = memoryWritebackPayload; want = expq.pop_front();
    if (got !== want) begin
      errors++; $display("FAIL lw_forced_payload: got %h required %h", got, want);
    end
    next_cycle();
    executeMemoryPayload = op(1'b0, 1'b1, 3'b001, 32'h203, 32'h0000_BEEF, 32'h0, 5'd14, 1'b0);
    @(negedge clock);
    checks++; got = memoryWritebackPayload; want = expq.pop_front();
    if (got !== want) begin
      errors++; $display("FAIL lh_forced_payload: got %h required %h", got, want);
    end
    checks++;
    if (memRequest !== 1'b1 || memByteEnable !== 4'b1100 || memAddress !== 32'h200) begin
      errors++; $display("FAIL sh_forced_align: req=%b be=%b addr=%h required 1 1100 00000200",
                         memRequest, memByteEnable, memAddress);
    end
    next_cycle();
    drive_idle();
    next_cycle();
`endif
  endtask

  task automatic test_flush();
    executeMemoryPayload = op(1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 32'h0, 5'd9, 1'b1);
    memReadData = 32'h5555_AAAA;
    for (int c = 0; c < 5; c++) begin
      flush = (c == 2);
      memReady = (c == 4);
      @(negedge clock);
      checks++;
      if (memRequest !== 1'b1 || memAddress !== 32'h108) begin
        errors++; $display("FAIL flush_wait_held[%0d]: req=%b addr=%h required 1 00000108", c, memRequest, memAddress);
      end
      next_cycle();
    end
    drive_idle();
    @(negedge clock);
    checks++;
    if (memoryWritebackPayload.valid !== 1'b0 || memRequest !== 1'b0) begin
      errors++; $display("FAIL flush_wait_drop: valid=%b req=%b required 0 0", memoryWritebackPayload.valid, memRequest);
    end
    // flush coinciding with memReady
    executeMemoryPayload = op(1'b1, 1'b0, 3'b010, 32'h10C, 32'h0, 32'h0, 5'd9, 1'b1);
    next_cycle();
    flush = 1'b1; memReady = 1'b1;
    next_cycle();
    drive_idle();
    @(negedge clock);
    checks++;
    if (memoryWritebackPayload.valid !== 1'b0) begin
      errors++; $display("FAIL flush_ready_drop: valid=%b required 0", memoryWritebackPayload.valid);
    end
    // flush while IDLE
    executeMemoryPayload = op(1'b1, 1'b0, 3'b010, 32'h110, 32'h0, 32'h0, 5'd9, 1'b1);
    flush = 1'b1; memReady = 1'b1;
    @(negedge clock);
    checks++;
    if (memRequest !== 1'b0) begin
      errors++; $display("FAIL flush_idle_request: req=%b required 0", memRequest);
    end
    next_cycle();
    executeMemoryPayload = op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h77, 5'd4, 1'b1);
    @(negedge clock);
    checks++;
    if (memoryWritebackPayload.valid !== 1'b0) begin
      errors++; $display("FAIL flush_idle_load_drop: valid=%b required 0", memoryWritebackPayload.valid);
    end
    next_cycle();
    drive_idle();
    @(negedge clock);
    checks++;
    if (memoryWritebackPayload.valid !== 1'b0) begin
      errors++; $display("FAIL flush_idle_alu_drop: valid=%b required 0", memoryWritebackPayload.valid);
    end
    next_cycle();
  endtask

  task automatic test_watchdog();
    int  stallCycles = 0;
    logic released = 1'b0;
    executeMemoryPayload = op(1'b1, 1'b0, 3'b010, 32'h110, 32'h0, 32'h0, 5'd10, 1'b1);
    for (int c = 0; c < 20 && !released; c++) begin
      @(negedge clock);
      if (memoryStall === 1'b1) stallCycles++;
      else released = 1'b1;
      next_cycle();
    end
    checks++;
    if (!released || stallCycles != 4) begin
      errors++; $display("FAIL watchdog_stall: released=%b stall_cycles=%0d required 1 4", released, stallCycles);
    end
    drive_idle();
    @(negedge clock);
    checks++;
    if (memoryWritebackPayload.valid !== 1'b1 || memoryWritebackPayload.illegal !== 1'b1 ||
        memoryWritebackPayload.destinationRegister !== 5'd10 || memRequest !== 1'b0 || memoryStall !== 1'b0) begin
      errors++; $display("FAIL watchdog_payload: got %h req=%b stall=%b required valid=1 illegal=1 rd=10 req=0 stall=0",
                         memoryWritebackPayload, memRequest, memoryStall);
    end
    next_cycle();
  endtask

  task automatic test_reset_in_wait();
    executeMemoryPayload = op(1'b1, 1'b0, 3'b010, 32'h114, 32'h0, 32'h0, 5'd8, 1'b1);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    drive_idle();
    @(negedge clock);
    checks++;
    if (memRequest !== 1'b0 || memoryWritebackPayload.valid !== 1'b0) begin
      errors++; $display("FAIL reset_in_wait: req=%b valid=%b required 0 0", memRequest, memoryWritebackPayload.valid);
    end
    next_cycle();
    executeMemoryPayload = op(1'b1, 1'b0, 3'b100, 32'h115, 32'h0, 32'h0, 5'd8, 1'b1);
    memReadData = 32'h0000_9900;
    memReady = 1'b1;
    expq.push_back(wbp(1'b1, 1'b1, 1'b0, 5'd8, 32'h0000_0099));
    @(negedge clock);
    checks++;
    if (memRequest !== 1'b1 || memoryStall !== 1'b0) begin
      errors++; $display("FAIL after_reset_request: req=%b stall=%b required 1 0", memRequest, memoryStall);
    end
    next_cycle();
    drive_idle();
    @(negedge clock);
    checks++; got = memoryWritebackPayload; want = expq.pop_front();
    if (got !== want) begin
      errors++; $display("FAIL after_reset_payload: got %h required %h", got, want);
    end
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_alu_ops();
    test_illegal_funct3();
    test_back_to_back_loads();
    test_load_wait();
    test_store_lanes();
    test_misaligned();
    test_flush();
    test_watchdog();
    test_reset_in_wait();
    checks++;
    if (expq.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left, required 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
